// File: rtl/readout_scan_ctrl.sv
// Readout sequencer: scans (sample, channel, chip) words of one event, one FIFO read per accepted word.
// Optional READOUT_EVT_CNT_EN adds a 16-bit completed-event counter output EVT_CNT.
module readout_scan_ctrl #(
  parameter  int NCHIP  = 5,
  parameter  int NCHAN  = 16,
  parameter  int SAMP_W = 7,
  localparam int CHIP_W = (NCHIP > 1) ? $clog2(NCHIP) : 1,
  localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RDY,
  input  logic              JTAG_MODE,
  input  logic              ABORT,
  input  logic [SAMP_W-1:0] SAMP_MAX,
  input  logic              DS_RDY,
  output logic              RDENA,
  output logic [CHIP_W-1:0] CHIP,
  output logic [CHAN_W-1:0] CHAN,
  output logic [SAMP_W-1:0] SAMP,
  output logic              FIRST_WORD,
  output logic              LAST_WORD,
  output logic              BUSY,
  output logic              EVT_DONE
`ifdef READOUT_EVT_CNT_EN
  ,
  output logic [15:0]       EVT_CNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CHIP_W-1:0] chip_r;
  logic [CHAN_W-1:0] chan_r;
  logic [SAMP_W-1:0] samp_r;
  logic [SAMP_W-1:0] smax_r;

  logic start_ok;
  logic chip_end, chan_end, samp_end, final_w;
  logic rdena, load, clr;

  assign start_ok = RDY && !JTAG_MODE && !ABORT;
  assign chip_end = (chip_r == CHIP_W'(NCHIP - 1));
  assign chan_end = (chan_r == CHAN_W'(NCHAN - 1));
  assign samp_end = (samp_r == smax_r);
  assign final_w  = chip_end && chan_end && samp_end;

  // ABORT outranks every other transition in READ and DONE
  always_comb begin
    state_nx = state;
    rdena    = 1'b0;
    load     = 1'b0;
    clr      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nx = S_READ;
          load     = 1'b1;
          clr      = 1'b1;
        end
      end
      S_READ: begin
        if (ABORT) begin
          state_nx = S_IDLE;
          clr      = 1'b1;
        end else if (DS_RDY) begin
          rdena = 1'b1;
          if (final_w) begin
            state_nx = S_DONE;
            clr      = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (ABORT) begin
          state_nx = S_IDLE;
          clr      = 1'b1;
        end else if (start_ok) begin
          state_nx = S_READ;
          load     = 1'b1;
          clr      = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        clr      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      chip_r <= '0;
      chan_r <= '0;
      samp_r <= '0;
      smax_r <= '0;
    end else begin
      state <= state_nx;
      if (load) smax_r <= SAMP_MAX;
      if (clr) begin
        chip_r <= '0;
        chan_r <= '0;
        samp_r <= '0;
      end else if (rdena) begin
        // chip innermost, then channel, then sample
        if (!chip_end) begin
          chip_r <= chip_r + CHIP_W'(1);
        end else begin
          chip_r <= '0;
          if (!chan_end) begin
            chan_r <= chan_r + CHAN_W'(1);
          end else begin
            chan_r <= '0;
            samp_r <= samp_r + SAMP_W'(1);
          end
        end
      end
    end
  end

  assign RDENA      = rdena;
  assign CHIP       = chip_r;
  assign CHAN       = chan_r;
  assign SAMP       = samp_r;
  assign FIRST_WORD = rdena && (chip_r == '0) && (chan_r == '0) && (samp_r == '0);
  assign LAST_WORD  = rdena && final_w;
  assign BUSY       = (state == S_READ) || (state == S_DONE);
  assign EVT_DONE   = (state == S_DONE) && !ABORT;

`ifdef READOUT_EVT_CNT_EN
  logic [15:0] evt_cnt_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) evt_cnt_r <= '0;
    else if (EVT_DONE) evt_cnt_r <= evt_cnt_r + 16'd1;
  end

  assign EVT_CNT = evt_cnt_r;
`endif

endmodule

// File: tb/tb_readout_scan_ctrl.sv
// Directed testbench for readout_scan_ctrl with default parameters (5 chips, 16 channels, 7-bit samples).
module tb_readout_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST, RDY, JTAG_MODE, ABORT, DS_RDY;
  logic [6:0] SAMP_MAX;
  logic       RDENA, FIRST_WORD, LAST_WORD, BUSY, EVT_DONE;
  logic [2:0] CHIP;
  logic [3:0] CHAN;
  logic [6:0] SAMP;
`ifdef READOUT_EVT_CNT_EN
  logic [15:0] EVT_CNT;
`endif

  readout_scan_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .RDY        (RDY),
    .JTAG_MODE  (JTAG_MODE),
    .ABORT      (ABORT),
    .SAMP_MAX   (SAMP_MAX),
    .DS_RDY     (DS_RDY),
    .RDENA      (RDENA),
    .CHIP       (CHIP),
    .CHAN       (CHAN),
    .SAMP       (SAMP),
    .FIRST_WORD (FIRST_WORD),
    .LAST_WORD  (LAST_WORD),
    .BUSY       (BUSY),
    .EVT_DONE   (EVT_DONE)
`ifdef READOUT_EVT_CNT_EN
    ,
    .EVT_CNT    (EVT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called with the DUT entering READ at the next negedge; returns just after the final word.
  task automatic run_event(input int smax, input int stall_at, input int stall_len, input string tg);
    int   total, words, bad, stalls, first_cyc;
    logic ds;
    total     = 80 * (smax + 1);
    words     = 0;
    bad       = 0;
    stalls    = 0;
    first_cyc = -1;
    for (int cyc = 0; cyc < total + stall_len + 20 && words < total; cyc++) begin
      @(negedge CLK);
      ds = !(words == stall_at && stalls < stall_len);
      if (!ds) stalls++;
      DS_RDY = ds;
      #1;
      if (RDENA !== ds || BUSY !== 1'b1 || EVT_DONE !== 1'b0) bad++;
      if (CHIP !== 3'(words % 5) || CHAN !== 4'((words / 5) % 16) || SAMP !== 7'(words / 80)) bad++;
      if (RDENA === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (FIRST_WORD !== (words == 0)) bad++;
        if (LAST_WORD !== (words == total - 1)) bad++;
        words++;
      end else if (FIRST_WORD !== 1'b0 || LAST_WORD !== 1'b0) begin
        bad++;
      end
    end
    DS_RDY = 1'b1;
    check_val({tg, "_words"}, words, total);
    check_val({tg, "_bad"}, bad, 0);
    check_val({tg, "_lead"}, first_cyc, 0);
  endtask

  task automatic check_done(input string tg);
    @(negedge CLK);
    #1;
    check_val({tg, "_evt_done"}, EVT_DONE, 1);
    check_val({tg, "_done_busy"}, BUSY, 1);
    check_val({tg, "_done_rdena"}, RDENA, 0);
  endtask

  initial begin
    int words, bad;
    RST = 1'b1; RDY = 1'b0; JTAG_MODE = 1'b0; ABORT = 1'b0; DS_RDY = 1'b1; SAMP_MAX = 7'd2;
    #2;
    check_val("rst_rdena", RDENA, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_evt_done", EVT_DONE, 0);
    check_val("rst_idx", {SAMP, CHAN, CHIP}, 0);
    check_val("rst_first_last", {FIRST_WORD, LAST_WORD}, 0);
    @(negedge CLK);
    RST = 1'b0;

    // E1: 240 contiguous words; a mid-event SAMP_MAX change must be ignored
    @(negedge CLK);
    RDY = 1'b1;
    #1;
    check_val("e1_idle_rdena", RDENA, 0);
    check_val("e1_idle_busy", BUSY, 0);
    @(posedge CLK);
    #1;
    RDY = 1'b0;
    SAMP_MAX = 7'd5;
    run_event(2, -1, 0, "e1");
    check_done("e1");
    @(negedge CLK);
    #1;
    check_val("e1_back_idle", BUSY, 0);

    // E2: 3-cycle stall after word 7
    SAMP_MAX = 7'd2;
    RDY = 1'b1;
    @(posedge CLK);
    #1;
    RDY = 1'b0;
    run_event(2, 7, 3, "e2");
    check_done("e2");

    // E3: back-to-back events, second relatches SAMP_MAX=1
    @(negedge CLK);
    SAMP_MAX = 7'd0;
    RDY = 1'b1;
    @(posedge CLK);
    #1;
    run_event(0, -1, 0, "e3a");
    SAMP_MAX = 7'd1;
    check_done("e3a");
    @(posedge CLK);
    #1;
    RDY = 1'b0;
    run_event(1, -1, 0, "e3b");
    check_done("e3b");
    @(negedge CLK);
    #1;
    check_val("e3_back_idle", BUSY, 0);

    // JTAG gating, JTAG rising mid-event, then ABORT at word 50
    JTAG_MODE = 1'b1;
    RDY = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge CLK);
      #1;
      if (RDENA !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    check_val("jtag_block", bad, 0);
    @(negedge CLK);
    JTAG_MODE = 1'b0;
    SAMP_MAX = 7'd2;
    @(posedge CLK);
    #1;
    RDY = 1'b0;
    words = 0;
    bad = 0;
    for (int cyc = 0; cyc < 100 && words < 50; cyc++) begin
      @(negedge CLK);
      if (words == 10) JTAG_MODE = 1'b1;
      #1;
      if (RDENA !== 1'b1) bad++;
      else words++;
    end
    check_val("jtag_words", words, 50);
    check_val("jtag_contig", bad, 0);
    @(negedge CLK);
    ABORT = 1'b1;
    #1;
    check_val("abort_rdena", RDENA, 0);
    check_val("abort_evt_done", EVT_DONE, 0);
    check_val("abort_last", LAST_WORD, 0);
    check_val("abort_chan", CHAN, 10);
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    JTAG_MODE = 1'b0;
    @(negedge CLK);
    #1;
    check_val("abort_idle_busy", BUSY, 0);
    check_val("abort_idx_clr", {SAMP, CHAN, CHIP}, 0);
    check_val("abort_no_done", EVT_DONE, 0);
    check_val("abort_idle_rdena", RDENA, 0);
`ifdef READOUT_EVT_CNT_EN
    check_val("evt_cnt_4", EVT_CNT, 4);
`endif

    // E5: full sample range, SAMP must reach 127 without wrapping
    SAMP_MAX = 7'd127;
    RDY = 1'b1;
    @(posedge CLK);
    #1;
    RDY = 1'b0;
    run_event(127, -1, 0, "e5");
    check_done("e5");
`ifdef READOUT_EVT_CNT_EN
    @(negedge CLK);
    #1;
    check_val("evt_cnt_5", EVT_CNT, 5);
`endif

    // Async reset in the middle of an event
    @(negedge CLK);
    SAMP_MAX = 7'd2;
    RDY = 1'b1;
    @(posedge CLK);
    #1;
    RDY = 1'b0;
    repeat (21) @(negedge CLK);
    #1;
    check_val("pre_rst_rdena", RDENA, 1);
    #2;
    RST = 1'b1;
    #1;
    check_val("arst_rdena", RDENA, 0);
    check_val("arst_busy", BUSY, 0);
    check_val("arst_idx", {SAMP, CHAN, CHIP}, 0);
    check_val("arst_first_last", {FIRST_WORD, LAST_WORD, EVT_DONE}, 0);
`ifdef READOUT_EVT_CNT_EN
    check_val("arst_evt_cnt", EVT_CNT, 0);
`endif
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/readout_scan_ctrl.md
Name: readout_scan_ctrl

Overview:
Parametrised readout sequencer for the sample FIFO bank. It scans every (sample, channel, chip) word of one event: chip is the innermost index, then channel, then sample. It issues one FIFO read per accepted word and honours downstream backpressure. Chip, channel and sample counters are held inside the block; it does not rely on external counters.

Parameters:
NCHIP, 5, number of chips scanned per channel (>=1)
NCHAN, 16, channels per chip (>=1)
SAMP_W, 7, width of the sample index and of SAMP_MAX
CHIP_W, derived localparam, max(1, clog2(NCHIP))
CHAN_W, derived localparam, max(1, clog2(NCHAN))

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
RDY  in  1  event available in FIFOs
JTAG_MODE  in  1  JTAG readout owns FIFOs; blocks starting a new event
ABORT  in  1  synchronous abort of the current event
SAMP_MAX  in  SAMP_W  last sample index (inclusive); latched at event start
DS_RDY  in  1  downstream can accept a word this cycle
RDENA  out  1  FIFO read strobe; one word accepted per high cycle
CHIP  out  CHIP_W  chip index of the current word
CHAN  out  CHAN_W  channel index of the current word
SAMP  out  SAMP_W  sample index of the current word
FIRST_WORD  out  1  RDENA for word (0,0,0)
LAST_WORD  out  1  RDENA for the final word of the event
BUSY  out  1  high in READ and DONE
EVT_DONE  out  1  one-cycle pulse in DONE

Behaviour:
- States: IDLE, READ, DONE.
- Reset (async): state=IDLE; CHIP, CHAN and SAMP = 0; smax_r=0. All outputs 0.
- IDLE:
  - If RDY && !JTAG_MODE && !ABORT: latch smax_r<=SAMP_MAX, clear counters, go READ next cycle.
  - Otherwise stay in IDLE.
- RDENA = (state==READ) && DS_RDY && !ABORT. This output is combinational and has zero latency from DS_RDY.
- READ, on each RDENA cycle, the counters advance at the clock edge:
  - If CHIP<NCHIP-1: CHIP++.
  - Otherwise CHIP<=0. Then if CHAN<NCHAN-1, CHAN++; otherwise CHAN<=0 and SAMP++.
- READ with DS_RDY low: counters hold and RDENA=0. There is no timeout.
- Final word: CHIP==NCHIP-1 && CHAN==NCHAN-1 && SAMP==smax_r.
  - RDENA in this cycle also raises LAST_WORD.
  - Next state is DONE. Counters clear to 0.
- Changes to SAMP_MAX mid-event are ignored.
  - smax_r=0 gives one sample (NCHIP*NCHAN words).
  - smax_r=2^SAMP_W-1 reads the full range; SAMP never wraps inside an event.
- DONE lasts exactly 1 cycle with EVT_DONE=1.
  - If RDY && !JTAG_MODE && !ABORT: relatch SAMP_MAX and go straight to READ (back-to-back events, no IDLE cycle).
  - Otherwise go to IDLE.
- ABORT in READ or DONE:
  - RDENA is forced 0 that cycle.
  - Next state is IDLE; counters clear.
  - No EVT_DONE or LAST_WORD is issued.
  - ABORT has priority over all other transitions.
- JTAG_MODE rising mid-event does not interrupt the event; it only gates the next start.
- FIRST_WORD = RDENA && CHIP==0 && CHAN==0 && SAMP==0.
- Word count per event = NCHIP*NCHAN*(smax_r+1).
- The default state-decode branch returns to IDLE (safe recovery).

Optional Feature:
READOUT_EVT_CNT_EN:
- When defined, adds output EVT_CNT[15:0].
  - Increments on each EVT_DONE pulse and wraps 0xFFFF->0.
  - Cleared by RST only; ABORT does not count.
- When undefined, the port and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Defaults, SAMP_MAX=2, DS_RDY=1, RDY pulsed in IDLE -> READ starts next cycle; exactly 240 contiguous RDENA; order (s,c,h) = (0,0,0),(0,0,1)...(0,0,4),(0,1,0)...(2,15,4); LAST_WORD on word 240; EVT_DONE one cycle later; FIRST_WORD only on word 1.
- Same event, DS_RDY low for 3 cycles after word 7 -> RDENA low 3 cycles; indices hold at (0,1,2); still 240 words in total with no duplicates or skips.
- RDY held high with SAMP_MAX=0 -> 80 words, DONE, then a new event starts with no IDLE cycle; second event relatches SAMP_MAX=1 and gives 160 words.
- JTAG_MODE=1 with RDY=1 -> remains in IDLE, RDENA never asserts; JTAG_MODE->0 -> READ next cycle.
- ABORT at word 50 -> RDENA 0 that cycle; IDLE next cycle; counters 0; no EVT_DONE. RST asserted mid-event -> all outputs 0 immediately (async).
- With READOUT_EVT_CNT_EN: 3 complete events plus 1 aborted -> EVT_CNT=3; preload-style run of 65536 events -> EVT_CNT wraps to 0.
